// File: rtl/pc_update.sv
// pc_update: next-PC selection and PC register for the sequential Y86-64 core.
// Selects between fall-through (valP), constant target (valC) and memory
// return address (valM) from the completing instruction's icode and branch
// condition; halt and invalid icodes hold the current PC.
module pc_update (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic        j_cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] pc_new
);

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned ICODE_W = 4;

  // Instruction codes relevant to next-PC selection.
  typedef enum logic [ICODE_W-1:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_CMOVXX = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  logic [ADDR_W-1:0] pc_next_c;

  // Next-PC mux; j_cnd is only consulted for jXX so X elsewhere cannot leak.
  always_comb begin
    pc_next_c = pc_new;
    case (icode)
      I_JXX:    pc_next_c = j_cnd ? valC : valP;
      I_CALL:   pc_next_c = valC;
      I_RET:    pc_next_c = valM;
      I_NOP,
      I_CMOVXX,
      I_IRMOVQ,
      I_RMMOVQ,
      I_MRMOVQ,
      I_OPQ,
      I_PUSHQ,
      I_POPQ:   pc_next_c = valP;
      I_HALT:   pc_next_c = pc_new;
      default:  pc_next_c = pc_new;
    endcase
  end

  // PC register with synchronous active-high reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_new <= ADDR_W'(0);
    end else begin
      pc_new <= pc_next_c;
    end
  end

endmodule

// File: tb/tb_pc_update.sv
// Self-checking bench for pc_update: directed cases plus randomized sequences
// compared against a behavioural next-PC model.
module tb_pc_update;

  logic        clk;
  logic        reset;
  logic [3:0]  icode;
  logic        j_cnd;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] valM;
  logic [63:0] pc_new;

  int unsigned total;
  int unsigned bad;
  logic [63:0] model_pc;

  pc_update dut (
    .clk    (clk),
    .reset  (reset),
    .icode  (icode),
    .j_cnd  (j_cnd),
    .valC   (valC),
    .valP   (valP),
    .valM   (valM),
    .pc_new (pc_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference next PC computed straight from the instruction semantics.
  function automatic logic [63:0] ref_next(input logic rst, input logic [3:0] ic,
                                           input logic jc, input logic [63:0] c,
                                           input logic [63:0] p, input logic [63:0] m,
                                           input logic [63:0] cur);
    if (rst) return 64'h0;
    if (ic == 4'd8 || (ic == 4'd7 && jc)) return c;
    if (ic == 4'd9) return m;
    if (ic >= 4'd1 && ic <= 4'd11) return p;
    return cur;
  endfunction

  // Apply inputs, take one rising edge, then update the model.
  task automatic step(input logic rst, input logic [3:0] ic, input logic jc,
                      input logic [63:0] c, input logic [63:0] p, input logic [63:0] m);
    reset = rst; icode = ic; j_cnd = jc; valC = c; valP = p; valM = m;
    model_pc = ref_next(rst, ic, jc, c, p, m, model_pc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_pc = 64'h0;
    reset = 1'b0; icode = 4'h0; j_cnd = 1'b0; valC = '0; valP = '0; valM = '0;
    @(negedge clk);

    // Reset, held for two edges.
    step(1'b1, 4'h7, 1'b1, 64'h1, 64'h3, 64'h5);
    check("reset_edge1", pc_new, 64'h0);
    step(1'b1, 4'h7, 1'b1, 64'h1, 64'h3, 64'h5);
    check("reset_edge2", pc_new, 64'h0);

    // Taken jump; verify nothing moves before the edge.
    reset = 1'b0;
    #2;
    check("pre_edge_hold", pc_new, 64'h0);
    step(1'b0, 4'h7, 1'b1, 64'h1, 64'h3, 64'h5);
    check("jxx_taken", pc_new, 64'h1);

    // Inputs changing between edges must not disturb the register.
    valC = 64'hDEAD; icode = 4'h9; valM = 64'h77;
    #3;
    check("stable_between_edges", pc_new, 64'h1);

    step(1'b0, 4'h7, 1'b0, 64'h1, 64'h3, 64'h5);
    check("jxx_not_taken", pc_new, 64'h3);
    step(1'b0, 4'h6, 1'b1, 64'h1, 64'h0A, 64'h5);
    check("opq_fallthrough", pc_new, 64'h0A);

    // Call and return.
    step(1'b0, 4'h8, 1'b0, 64'h100, 64'h3, 64'h5);
    check("call", pc_new, 64'h100);
    step(1'b0, 4'h9, 1'b1, 64'h1, 64'h3, 64'h2A);
    check("ret", pc_new, 64'h2A);

    // Halt and invalid icodes hold.
    step(1'b0, 4'h3, 1'b0, 64'h0, 64'h40, 64'h0);
    check("load_0x40", pc_new, 64'h40);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 1'b1, 64'h55, 64'h99, 64'h66);
      check("halt_hold", pc_new, 64'h40);
    end
    step(1'b0, 4'hF, 1'b1, 64'h55, 64'h99, 64'h66);
    check("invalid_hold", pc_new, 64'h40);

    // Full-width value then mid-run reset.
    step(1'b0, 4'h8, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h3, 64'h5);
    check("call_wide", pc_new, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b1, 4'h8, 1'b1, 64'h1234, 64'h3, 64'h5);
    check("midrun_reset", pc_new, 64'h0);

    // Randomized sequences against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic [3:0]  ic;
      logic        jc;
      logic [63:0] c, p, m;
      r  = ($urandom_range(0, 19) == 0);
      ic = 4'($urandom_range(0, 15));
      jc = 1'($urandom);
      c  = {32'($urandom), 32'($urandom)};
      p  = {32'($urandom), 32'($urandom)};
      m  = {32'($urandom), 32'($urandom)};
      step(r, ic, jc, c, p, m);
      check("random", pc_new, model_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
